// File: rtl/fwd_scoreboard.sv
// -----------------------------------------------------------------------------
// fwd_scoreboard
//
// Forwarding and hazard unit for the decode stage of the multi-stage pipeline.
// It keeps one record {v, rd, rdy} per post-decode stage (stage 0 = E) and
// reports, per decode read port, which stage output to forward from. It raises
// stall when the youngest producer of a source has not reached its ready
// stage, when a source is pending in the long-latency unit, or when the decode
// instruction would overwrite (WAW) a register that is still pending.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          asynchronous active-high reset
//   issue_valid  decode instruction valid this cycle
//   issue_rd     decode destination register
//   issue_we     decode instruction writes issue_rd through the pipeline
//   issue_rdy    first stage index whose output carries the result
//   issue_long   decode instruction writes issue_rd via the long unit
//   rs           decode source registers, port i at [i*AW +: AW]
//   flush        kill the decode instruction (bubble into stage 0)
//   lop_done     long unit writes back lop_rd this cycle
//   lop_rd       long unit destination
//   fwd_sel      per port: 0 = regfile, k+1 = forward from stage k output
//   stall        hold F/D and insert a bubble into stage 0
//   stall_cnt    saturating count of stall cycles
//
// Decode handshake: the decode instruction is accepted on a rising edge when
// issue_valid=1, stall=0 and flush=0. stall depends only on current state and
// decode inputs; it is never asserted while issue_valid=0. A flushed
// instruction is dropped, but flush does not hide a stall.
// -----------------------------------------------------------------------------
module fwd_scoreboard #(
  parameter int NSTAGE = 3,
  parameter int NREAD  = 2,
  parameter int AW     = 5,
  parameter int SELW   = $clog2(NSTAGE + 1),
  parameter int CNTW   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  input  logic [AW-1:0]         issue_rd,
  input  logic                  issue_we,
  input  logic [SELW-1:0]       issue_rdy,
  input  logic                  issue_long,
  input  logic [NREAD*AW-1:0]   rs,
  input  logic                  flush,
  input  logic                  lop_done,
  input  logic [AW-1:0]         lop_rd,
  output logic [NREAD*SELW-1:0] fwd_sel,
  output logic                  stall,
  output logic [CNTW-1:0]       stall_cnt
);

  localparam int NREG = 1 << AW;

  // Per-stage in-flight write records.
  logic            rec_v   [NSTAGE];
  logic [AW-1:0]   rec_rd  [NSTAGE];
  logic [SELW-1:0] rec_rdy [NSTAGE];

  logic [NREG-1:0]  pending;
  logic [NREG-1:0]  pending_next;
  logic [AW-1:0]    src [NREAD];
  logic [NREAD-1:0] nrdy_hit;
  logic [NREAD-1:0] pend_hit;
  logic             waw_hit;
  logic             accept;
  logic             load_s0;

  for (genvar i = 0; i < NREAD; i++) begin : g_src
    assign src[i] = rs[i*AW +: AW];
  end

  // Walk stages from oldest to youngest so the youngest match overwrites any
  // older one. Register 0 never matches.
  always_comb begin
    fwd_sel  = '0;
    nrdy_hit = '0;
    pend_hit = '0;
    for (int i = 0; i < NREAD; i++) begin
      for (int k = NSTAGE - 1; k >= 0; k--) begin
        if (rec_v[k] && (rec_rd[k] == src[i]) && (src[i] != '0)) begin
          fwd_sel[i*SELW +: SELW] = SELW'(k + 1);
          // Data is not forwardable until the producer reaches stage rdy.
          nrdy_hit[i] = (SELW'(k) < rec_rdy[k]);
        end
      end
      pend_hit[i] = (src[i] != '0) && pending[src[i]];
    end
  end

  assign waw_hit = (issue_we || issue_long) && (issue_rd != '0) && pending[issue_rd];
  assign stall   = issue_valid && ((|nrdy_hit) || (|pend_hit) || waw_hit);
  assign accept  = issue_valid && !stall && !flush;
  assign load_s0 = accept && issue_we && (issue_rd != '0);

  // Clear is applied first so a same-cycle set on the same register wins.
  always_comb begin
    pending_next = pending;
    if (lop_done && (lop_rd != '0)) begin
      pending_next[lop_rd] = 1'b0;
    end
    if (accept && issue_long && (issue_rd != '0)) begin
      pending_next[issue_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NSTAGE; k++) begin
        rec_v[k]   <= 1'b0;
        rec_rd[k]  <= '0;
        rec_rdy[k] <= '0;
      end
      pending   <= '0;
      stall_cnt <= '0;
    end else begin
      // Records advance every cycle; the last stage simply drops off.
      for (int k = NSTAGE - 1; k >= 1; k--) begin
        rec_v[k]   <= rec_v[k-1];
        rec_rd[k]  <= rec_rd[k-1];
        rec_rdy[k] <= rec_rdy[k-1];
      end
      rec_v[0]   <= load_s0;
      rec_rd[0]  <= load_s0 ? issue_rd  : '0;
      rec_rdy[0] <= load_s0 ? issue_rdy : '0;
      pending    <= pending_next;
      if (stall && (stall_cnt != {CNTW{1'b1}})) begin
        stall_cnt <= stall_cnt + CNTW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_fwd_scoreboard
//
// Bench for fwd_scoreboard (NSTAGE=3, NREAD=2, AW=5). A second instance with
// CNTW=2 shares all inputs to exercise stall counter saturation. The reference
// model keeps in-flight writes as a list of {issue cycle, rd, rdy}; a record's
// stage is derived from its age, and the youngest matching issue wins.
// -----------------------------------------------------------------------------
module tb_fwd_scoreboard;

  localparam int NSTAGE = 3;
  localparam int NREAD  = 2;
  localparam int AW     = 5;
  localparam int SELW   = 2;
  localparam int CNTW   = 16;
  localparam int W      = NREAD*SELW + 1 + CNTW + 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  issue_valid = 1'b0;
  logic [AW-1:0]         issue_rd = '0;
  logic                  issue_we = 1'b0;
  logic [SELW-1:0]       issue_rdy = '0;
  logic                  issue_long = 1'b0;
  logic [NREAD*AW-1:0]   rs = '0;
  logic                  flush = 1'b0;
  logic                  lop_done = 1'b0;
  logic [AW-1:0]         lop_rd = '0;
  logic [NREAD*SELW-1:0] fwd_sel, fwd_sel_s;
  logic                  stall, stall_s;
  logic [CNTW-1:0]       stall_cnt;
  logic [1:0]            stall_cnt_s;

  fwd_scoreboard #(.NSTAGE(NSTAGE), .NREAD(NREAD), .AW(AW), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_we(issue_we), .issue_rdy(issue_rdy), .issue_long(issue_long),
    .rs(rs), .flush(flush), .lop_done(lop_done), .lop_rd(lop_rd),
    .fwd_sel(fwd_sel), .stall(stall), .stall_cnt(stall_cnt)
  );

  fwd_scoreboard #(.NSTAGE(NSTAGE), .NREAD(NREAD), .AW(AW), .CNTW(2)) dut_small (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_we(issue_we), .issue_rdy(issue_rdy), .issue_long(issue_long),
    .rs(rs), .flush(flush), .lop_done(lop_done), .lop_rd(lop_rd),
    .fwd_sel(fwd_sel_s), .stall(stall_s), .stall_cnt(stall_cnt_s)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  typedef struct {
    int            t;
    logic [AW-1:0] rd;
    int            rdy;
  } rec_t;

  rec_t          inflight[$];
  bit            pend_m[32];
  int            cyc = 0;
  int            cnt_m = 0;
  logic [W-1:0]  exp_q[$];
  int            checks = 0;
  int            failures = 0;

  function automatic void model_port(input logic [AW-1:0] r, output int sel, output bit nr);
    int best_t;
    best_t = -1;
    sel = 0;
    nr = 1'b0;
    foreach (inflight[j]) begin
      int k;
      k = cyc - inflight[j].t - 1;
      if (r != 0 && inflight[j].rd == r && k >= 0 && k < NSTAGE && inflight[j].t > best_t) begin
        best_t = inflight[j].t;
        sel = k + 1;
        nr = (k < inflight[j].rdy);
      end
    end
  endfunction

  function automatic bit model_stall();
    int s;
    bit n0, n1, h;
    logic [AW-1:0] r0, r1;
    if (!issue_valid) return 1'b0;
    r0 = rs[AW-1:0];
    r1 = rs[2*AW-1:AW];
    model_port(r0, s, n0);
    model_port(r1, s, n1);
    h = n0 || n1;
    if (r0 != 0 && pend_m[r0]) h = 1'b1;
    if (r1 != 0 && pend_m[r1]) h = 1'b1;
    if ((issue_we || issue_long) && issue_rd != 0 && pend_m[issue_rd]) h = 1'b1;
    return h;
  endfunction

  function automatic void push_expect();
    int s0, s1, c16, c2;
    bit n0, n1, st;
    model_port(rs[AW-1:0], s0, n0);
    model_port(rs[2*AW-1:AW], s1, n1);
    st  = model_stall();
    c16 = (cnt_m > 65535) ? 65535 : cnt_m;
    c2  = (cnt_m > 3) ? 3 : cnt_m;
    exp_q.push_back({2'(s1), 2'(s0), st, 16'(c16), 2'(c2)});
  endfunction

  function automatic void model_clear();
    inflight.delete();
    foreach (pend_m[j]) pend_m[j] = 1'b0;
    cnt_m = 0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [AW-1:0] d, input logic w,
                       input logic [SELW-1:0] r, input logic l,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic f, input logic ld, input logic [AW-1:0] lrd);
    issue_valid = v;
    issue_rd    = d;
    issue_we    = w;
    issue_rdy   = r;
    issue_long  = l;
    rs          = {a1, a0};
    flush       = f;
    lop_done    = ld;
    lop_rd      = lrd;
  endtask

  task automatic drive_idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Advance one clock, updating the model with the accepted decode actions.
  task automatic tick();
    bit s;
    s = model_stall();
    @(posedge clk);
    if (issue_valid && issue_we && issue_rd != 0 && !s && !flush)
      inflight.push_back('{t: cyc, rd: issue_rd, rdy: int'(issue_rdy)});
    if (lop_done && lop_rd != 0) pend_m[lop_rd] = 1'b0;
    if (issue_valid && issue_long && issue_rd != 0 && !s && !flush) pend_m[issue_rd] = 1'b1;
    if (s) cnt_m++;
    cyc++;
    while (inflight.size() > 0 && (cyc - inflight[0].t - 1) >= NSTAGE) void'(inflight.pop_front());
    #1;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      checks++;
      if ({fwd_sel, stall, stall_cnt, stall_cnt_s} !== '0) begin
        failures++;
        $display("FAIL reset_idle cycle=%0d got fwd_sel=%h stall=%b cnt=%0d cnt_s=%0d want all zero",
                 j, fwd_sel, stall, stall_cnt, stall_cnt_s);
      end
      tick();
    end
  endtask

  task automatic test_alu_chain();
    int exp_sel[4] = '{1, 2, 3, 0};
    logic [W-1:0] e;
    do_reset();
    drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    for (int j = 0; j < 4; j++) begin
      drive(0, 0, 0, 0, 0, 5, 0, 0, 0, 0);
      @(negedge clk);
      push_expect();
      e = exp_q.pop_front();
      checks++;
      if ({fwd_sel, stall, stall_cnt, stall_cnt_s} !== e) begin
        failures++;
        $display("FAIL alu_chain_model step=%0d got=%h want=%h", j, {fwd_sel, stall, stall_cnt, stall_cnt_s}, e);
      end
      checks++;
      if (fwd_sel[1:0] !== 2'(exp_sel[j]) || stall !== 1'b0) begin
        failures++;
        $display("FAIL alu_chain step=%0d got sel0=%0d stall=%b want sel0=%0d stall=0",
                 j, fwd_sel[1:0], stall, exp_sel[j]);
      end
      tick();
    end
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1, 7, 1, 1, 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 7, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (stall !== 1'b1 || fwd_sel[3:2] !== 2'd1) begin
      failures++;
      $display("FAIL load_use_t1 got stall=%b sel1=%0d want stall=1 sel1=1", stall, fwd_sel[3:2]);
    end
    tick();
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || fwd_sel[3:2] !== 2'd2 || stall_cnt !== 16'd1) begin
      failures++;
      $display("FAIL load_use_t2 got stall=%b sel1=%0d cnt=%0d want stall=0 sel1=2 cnt=1",
               stall, fwd_sel[3:2], stall_cnt);
    end
    tick();
  endtask

  task automatic test_youngest();
    do_reset();
    drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    drive(0, 0, 0, 0, 0, 3, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (fwd_sel[1:0] !== 2'd1 || stall !== 1'b0) begin
      failures++;
      $display("FAIL youngest got sel0=%0d stall=%b want sel0=1 stall=0", fwd_sel[1:0], stall);
    end
    tick();
    drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (fwd_sel !== '0 || stall !== 1'b0) begin
      failures++;
      $display("FAIL reg_zero got fwd_sel=%h stall=%b want 0 0", fwd_sel, stall);
    end
    tick();
  endtask

  task automatic test_long_op();
    do_reset();
    drive(1, 9, 0, 0, 1, 0, 0, 0, 0, 0);
    tick();
    for (int j = 1; j <= 5; j++) begin
      if (j % 2 == 1) drive(1, 0, 0, 0, 0, 9, 0, 0, 0, 0);
      else            drive(1, 9, 1, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      checks++;
      if (stall !== 1'b1) begin
        failures++;
        $display("FAIL long_pending step=%0d got stall=%b want 1", j, stall);
      end
      tick();
    end
    drive(1, 0, 0, 0, 0, 9, 0, 0, 1, 9);
    @(negedge clk);
    checks++;
    if (stall !== 1'b1) begin
      failures++;
      $display("FAIL long_done_cycle got stall=%b want 1", stall);
    end
    tick();
    drive(1, 0, 0, 0, 0, 9, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || stall_cnt !== 16'd6) begin
      failures++;
      $display("FAIL long_cleared got stall=%b cnt=%0d want stall=0 cnt=6", stall, stall_cnt);
    end
    tick();
    // Set and clear of the same register in one cycle: set wins.
    drive(1, 9, 0, 0, 1, 0, 0, 0, 1, 9);
    tick();
    drive(1, 0, 0, 0, 0, 0, 9, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (stall !== 1'b1) begin
      failures++;
      $display("FAIL set_clear_same got stall=%b want 1", stall);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 9);
    tick();
  endtask

  task automatic test_flush();
    do_reset();
    drive(1, 6, 1, 0, 0, 0, 0, 1, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 6, 6, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (fwd_sel !== '0) begin
      failures++;
      $display("FAIL flush_bubble got fwd_sel=%h want 0", fwd_sel);
    end
    tick();
    drive(1, 7, 1, 1, 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 7, 0, 1, 0, 0);
    @(negedge clk);
    checks++;
    if (stall !== 1'b1) begin
      failures++;
      $display("FAIL flush_keeps_stall got stall=%b want 1", stall);
    end
    tick();
    drive_idle();
    tick();
  endtask

  task automatic test_saturate();
    do_reset();
    drive(1, 10, 0, 0, 1, 0, 0, 0, 0, 0);
    tick();
    for (int j = 0; j < 5; j++) begin
      drive(1, 0, 0, 0, 0, 10, 0, 0, 0, 0);
      tick();
    end
    drive_idle();
    @(negedge clk);
    checks++;
    if (stall_cnt_s !== 2'd3 || stall_cnt !== 16'd5) begin
      failures++;
      $display("FAIL cnt_saturate got cnt_s=%0d cnt=%0d want cnt_s=3 cnt=5", stall_cnt_s, stall_cnt);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 10);
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1, 11, 0, 0, 1, 0, 0, 0, 0, 0);
    tick();
    drive(1, 12, 1, 2, 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 11, 12, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (stall !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_pre got stall=%b want 1", stall);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({fwd_sel, stall, stall_cnt, stall_cnt_s} !== '0) begin
      failures++;
      $display("FAIL reset_mid_async got fwd_sel=%h stall=%b cnt=%0d want all zero", fwd_sel, stall, stall_cnt);
    end
    model_clear();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({fwd_sel, stall, stall_cnt} !== '0) begin
      failures++;
      $display("FAIL reset_mid_after got fwd_sel=%h stall=%b cnt=%0d want all zero", fwd_sel, stall, stall_cnt);
    end
    tick();
  endtask

  task automatic test_random();
    logic [W-1:0] e;
    do_reset();
    for (int j = 0; j < 400; j++) begin
      drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom_range(0, 9) < 7,
            2'($urandom_range(0, 3)), $urandom_range(0, 11) == 0,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            $urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0, 5'($urandom_range(0, 7)));
      @(negedge clk);
      push_expect();
      e = exp_q.pop_front();
      checks++;
      if ({fwd_sel, stall, stall_cnt, stall_cnt_s} !== e) begin
        failures++;
        $display("FAIL random cycle=%0d got=%h want=%h", j, {fwd_sel, stall, stall_cnt, stall_cnt_s}, e);
      end
      tick();
    end
    drive_idle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_alu_chain();
    test_load_use();
    test_youngest();
    test_long_op();
    test_flush();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
